// File: rtl/quad_encoder_gen_if.sv
// Command and quadrature output bundle for quad_encoder_gen.
// There is no valid/ready. The commands are levels that are sampled on every clk edge, and all outputs are registered levels.
interface quad_encoder_gen_if #(
  parameter int POS_WIDTH = 16
);
  logic                 horario;
  logic                 antihorario;
  logic                 A;
  logic                 B;
  logic                 Z;
  logic                 dir;
  logic                 fault;
  logic [POS_WIDTH-1:0] position;
  logic [1:0]           state_dbg;

  modport master (
    output horario, antihorario,
    input  A, B, Z, dir, fault, position, state_dbg
  );

  modport slave (
    input  horario, antihorario,
    output A, B, Z, dir, fault, position, state_dbg
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns CW/CCW command levels into Gray-coded A/B steps,
// with signed position, revolution index pulse Z and conflict flag.
module quad_encoder_gen #(
   parameter int STEP_DIV  = 4,
   parameter int DIV_WIDTH = 16,
   parameter int POS_WIDTH = 16,
   parameter int PPR       = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   quad_encoder_gen_if.slave  bus
);
   localparam int REV_W = $clog2(4 * PPR);
   localparam logic [REV_W-1:0]     REV_LAST = REV_W'(4 * PPR - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_END  = DIV_WIDTH'(STEP_DIV);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_CW   = 2'd1,
      RUN_CCW  = 2'd2,
      CONFLICT = 2'd3
   } state_t;

   state_t               state, cls;
   logic [DIV_WIDTH-1:0] div, div_next;
   logic [1:0]           phase, phase_next;
   logic [REV_W-1:0]     rev, rev_next;
   logic [POS_WIDTH-1:0] pos_q;
   logic                 a_q, b_q, z_q, dir_q, fault_q;
   logic                 step;

   always_comb begin
      cls        = IDLE;
      div_next   = '0;
      step       = 1'b0;
      phase_next = phase;
      rev_next   = rev;
      case ({bus.horario, bus.antihorario})
         2'b10:   cls = RUN_CW;
         2'b01:   cls = RUN_CCW;
         2'b11:   cls = CONFLICT;
         default: cls = IDLE;
      endcase
      // A new or changed direction discards any partial count.
      if (cls == RUN_CW || cls == RUN_CCW) begin
         div_next = (cls == state) ? div + DIV_WIDTH'(1) : DIV_WIDTH'(1);
         step     = (div_next == DIV_END);
      end
      if (cls == RUN_CW) begin
         phase_next = phase + 2'd1;
         rev_next   = (rev == REV_LAST) ? '0 : rev + REV_W'(1);
      end else if (cls == RUN_CCW) begin
         phase_next = phase - 2'd1;
         rev_next   = (rev == '0) ? REV_LAST : rev - REV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         div     <= '0;
         phase   <= '0;
         rev     <= '0;
         pos_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         z_q     <= 1'b0;
         dir_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= cls;
         div     <= step ? '0 : div_next;
         fault_q <= (cls == CONFLICT);
         z_q     <= 1'b0;
         if (step) begin
            phase <= phase_next;
            rev   <= rev_next;
            // Phase to AB Gray map: 0->00, 1->10, 2->11, 3->01.
            a_q   <= phase_next[0] ^ phase_next[1];
            b_q   <= phase_next[1];
            z_q   <= (rev_next == '0);
            dir_q <= (cls == RUN_CW);
            pos_q <= (cls == RUN_CW) ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
         end
      end
   end

   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.Z         = z_q;
   assign bus.dir       = dir_q;
   assign bus.fault     = fault_q;
   assign bus.position  = pos_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen. dut1 uses STEP_DIV=4/PPR=256 and dut2 uses STEP_DIV=1/PPR=2.
// Both designs see the same commands.
module tb_quad_encoder_gen;
   localparam int PW = 16;

   int n_cmp = 0;
   int n_err = 0;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   quad_encoder_gen_if #(.POS_WIDTH(PW)) bus1 ();
   quad_encoder_gen_if #(.POS_WIDTH(PW)) bus2 ();

   quad_encoder_gen #(.STEP_DIV(4), .DIV_WIDTH(16), .POS_WIDTH(PW), .PPR(256)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   quad_encoder_gen #(.STEP_DIV(1), .DIV_WIDTH(16), .POS_WIDTH(PW), .PPR(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   // driver tasks
   task automatic set_cmd(input logic h, input logic a);
      bus1.horario     = h;
      bus1.antihorario = a;
      bus2.horario     = h;
      bus2.antihorario = a;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_cmd(1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ab1();
      return 32'({bus1.A, bus1.B});
   endfunction

   function automatic logic [31:0] ab2();
      return 32'({bus2.A, bus2.B});
   endfunction

   initial begin
      set_cmd(1'b0, 1'b0);
      do_reset();
      #1;
      check("rst_ab",    ab1(), 32'h0);
      check("rst_z",     32'(bus1.Z), 32'h0);
      check("rst_dir",   32'(bus1.dir), 32'h0);
      check("rst_fault", 32'(bus1.fault), 32'h0);
      check("rst_pos",   32'(bus1.position), 32'h0);
      check("rst_state", 32'(bus1.state_dbg), 32'h0);

      // CW held 16 edges: steps on edges 4/8/12/16, AB 10,11,01,00
      for (int e = 1; e <= 16; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
         case (e)
            3:  check("cw_e3_ab",  ab1(), 32'h0);
            4:  check("cw_e4_ab",  ab1(), 32'h2);
            8:  check("cw_e8_ab",  ab1(), 32'h3);
            12: check("cw_e12_ab", ab1(), 32'h1);
            16: check("cw_e16_ab", ab1(), 32'h0);
            default: ;
         endcase
      end
      check("cw_pos",   32'(bus1.position), 32'd4);
      check("cw_dir",   32'(bus1.dir), 32'h1);
      check("cw_fault", 32'(bus1.fault), 32'h0);
      check("cw_z",     32'(bus1.Z), 32'h0);

      // CCW held 8 edges from reset
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         set_cmd(1'b0, 1'b1);
         edge_wait();
         if (e == 4) check("ccw_e4_ab", ab1(), 32'h1);
      end
      check("ccw_e8_ab", ab1(), 32'h3);
      check("ccw_pos",   32'(bus1.position), 32'hFFFE);
      check("ccw_dir",   32'(bus1.dir), 32'h0);

      // conflict handling
      do_reset();
      for (int e = 1; e <= 2; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
      end
      for (int e = 1; e <= 3; e++) begin
         set_cmd(1'b1, 1'b1);
         edge_wait();
         check($sformatf("conf_fault%0d", e), 32'(bus1.fault), 32'h1);
         check($sformatf("conf_ab%0d", e), ab1(), 32'h0);
      end
      for (int e = 1; e <= 4; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
         if (e == 1) check("post_conf_fault", 32'(bus1.fault), 32'h0);
         if (e == 3) check("post_conf_e3_ab", ab1(), 32'h0);
      end
      check("post_conf_e4_ab", ab1(), 32'h2);
      check("post_conf_pos",   32'(bus1.position), 32'd1);

      // direction switch discards partial count
      do_reset();
      for (int e = 1; e <= 3; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
      end
      check("sw_cw_ab", ab1(), 32'h0);
      for (int e = 1; e <= 4; e++) begin
         set_cmd(1'b0, 1'b1);
         edge_wait();
         if (e == 3) check("sw_e3_ab", ab1(), 32'h0);
      end
      check("sw_e4_ab", ab1(), 32'h1);
      check("sw_pos",   32'(bus1.position), 32'hFFFF);
      check("sw_dir",   32'(bus1.dir), 32'h0);

      // asynchronous reset mid-run
      do_reset();
      for (int e = 1; e <= 10; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
      end
      check("mid_pre_ab",  ab1(), 32'h3);
      check("mid_pre_pos", 32'(bus1.position), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_ab",    ab1(), 32'h0);
      check("mid_z",     32'(bus1.Z), 32'h0);
      check("mid_dir",   32'(bus1.dir), 32'h0);
      check("mid_fault", 32'(bus1.fault), 32'h0);
      check("mid_pos",   32'(bus1.position), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         edge_wait();
         if (e == 3) check("mid_rel_e3_ab", ab1(), 32'h0);
      end
      check("mid_rel_e4_ab", ab1(), 32'h2);

      // PPR=2, STEP_DIV=1 index pulse
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         set_cmd(1'b1, 1'b0);
         edge_wait();
         if (e == 1) check("z_e1_ab", ab2(), 32'h2);
         if (e < 8) check($sformatf("z_e%0d", e), 32'(bus2.Z), 32'h0);
      end
      check("z_e8",     32'(bus2.Z), 32'h1);
      check("z_e8_ab",  ab2(), 32'h0);
      check("z_e8_pos", 32'(bus2.position), 32'd8);
      set_cmd(1'b0, 1'b1);
      edge_wait();
      check("z_back",     32'(bus2.Z), 32'h0);
      check("z_back_ab",  ab2(), 32'h1);
      check("z_back_pos", 32'(bus2.position), 32'd7);
      check("z_back_rev", 32'(u_dut2.rev), 32'd7);
      set_cmd(1'b1, 1'b0);
      edge_wait();
      check("z_fwd",    32'(bus2.Z), 32'h1);
      check("z_fwd_ab", ab2(), 32'h0);
      set_cmd(1'b0, 1'b0);
      edge_wait();
      check("z_clear",  32'(bus2.Z), 32'h0);

      // report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
Parametrised quadrature encoder emulator, successor to the single-pulse direction encoder. It converts clockwise/anticlockwise command levels into a true 2-bit Gray-code A/B quadrature sequence at a programmable step rate. It also tracks signed position and revolution phase, emits an index pulse Z, and flags conflicting commands. It sits between the user-command logic and the motor/encoder-interface test path.

Parameters:
STEP_DIV, 4, clock cycles of a held command per quadrature step (>=1)
DIV_WIDTH, 16, width of the step divider counter (2^DIV_WIDTH > STEP_DIV)
POS_WIDTH, 16, width of the position counter (two's complement, wraps)
PPR, 256, pulses per revolution; one revolution = 4*PPR steps

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
horario  input  1  clockwise command level
antihorario  input  1  anticlockwise command level
A  output  1  quadrature channel A (registered)
B  output  1  quadrature channel B (registered)
Z  output  1  index pulse, one clk wide (registered)
dir  output  1  direction of last step: 1=CW, 0=CCW
fault  output  1  high for each cycle following a sample with both commands high
position  output  POS_WIDTH  signed step count since reset

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0. Internal state: state=IDLE, div=0, phase=0, rev=0.
- Command class is sampled each rising edge. NONE = neither input high; CW = horario only; CCW = antihorario only; CONFLICT = both high.
- FSM states are IDLE, RUN_CW, RUN_CCW and CONFLICT. The next state is the sampled command class, so any state can move to any other in one edge.
- Divider:
  - When the class is CW or CCW and equals the current state, div increments.
  - When the class differs from the current state, div restarts at 1.
  - In NONE or CONFLICT, div is set to 0.
  - A step fires on the edge where the updated div would equal STEP_DIV. On that edge div is set to 0 instead.
  - Net effect: a step occurs on the STEP_DIV-th consecutive edge sampling the same valid command, then every STEP_DIV edges while the command is held.
  - With STEP_DIV=1, a step fires on every such edge.
- Step effects, all registered on the stepping edge:
  - phase becomes phase+1 mod 4 for CW, or phase-1 mod 4 for CCW.
  - AB mapping by phase: 0->00, 1->10, 2->11, 3->01. CW means A leads B. Exactly one of A/B changes per step.
  - position is incremented (CW) or decremented (CCW) modulo 2^POS_WIDTH.
  - dir is set to 1 for CW, 0 for CCW.
  - rev is incremented modulo 4*PPR (CW), or decremented with 0 wrapping to 4*PPR-1 (CCW).
- Z is 1 for exactly the edge on which a step makes rev become 0, in either direction. Otherwise Z is 0.
- A, B, position and dir hold their values whenever no step fires.
- fault is 1 exactly for each edge that sampled CONFLICT. While in CONFLICT, no step fires and A/B/position/rev are frozen.
- A direction change discards the partial divider count. No step can fire earlier than STEP_DIV edges into the new direction.
- Reset asserted mid-run returns all state to reset values immediately (asynchronous). The first step after release requires a full STEP_DIV count.
- No glitches: A/B change only at a clk edge, never both at once.

Test Plan:
- Reset mid-run: assert rst_n=0 between clock edges after several steps -> A=B=Z=fault=dir=0 and position=0 immediately, without a clk edge.
- STEP_DIV=4, horario held 16 edges -> steps on edges 4/8/12/16.
  - AB sequence: 10, 11, 01, 00.
  - Final state: position=4, dir=1, fault=0.
- STEP_DIV=4, antihorario held 8 edges from reset:
  - AB goes to 01 on edge 4, then 11 on edge 8.
  - position=16'hFFFE, dir=0.
- Conflict handling:
  - Hold horario 2 edges, then both inputs 3 edges -> fault=1 for those 3 cycles only, AB unchanged.
  - Then hold horario alone -> first step occurs 4 edges later.
- Direction switch: horario 3 edges then antihorario 4 edges -> no step during the horario phase; on the 4th antihorario edge AB goes 00->01 and position=-1.
- PPR=2, STEP_DIV=1:
  - horario for 8 edges -> Z high only on edge 8, AB back to 00, position=8.
  - Then antihorario 1 edge -> rev=7, Z=0.
  - Then horario 1 edge -> Z=1.
